ocx_dlx_tx_gbx: RTL

//  Per-lane 64b/66b TX gearbox; one instance per lane, directly downstream of the per-lane TX queue.

---
 rtl/ocx_dlx_tx_gbx.sv | 76 +++++++
 1 files changed

// File: rtl/ocx_dlx_tx_gbx.sv
// Per-lane 64b/66b TX gearbox: 32 accepted 66b blocks leave as 33 64b words.
// Optional sticky sync-header check when OCX_DLX_TX_GB_HDR_CHK_EN is defined.
module ocx_dlx_tx_gbx #(
  parameter logic [1:0] HDR_DATA = 2'b01,
  parameter logic [1:0] HDR_CTRL = 2'b10
) (
  input  logic        dlx_clk,
  input  logic        dlx_reset_n,
  input  logic        ctl_gb_reset,
  input  logic [1:0]  ctl_gb_header,
  input  logic [63:0] que_gb_data,
  output logic        gb_que_stall,
  output logic [63:0] gb_phy_data,
  output logic        gb_ctl_hdr_err
);

  localparam logic [5:0] SEQ_DRAIN = 6'd32;

  logic [5:0]   seq_q;
  logic [5:0]   seq_nxt;
  logic [63:0]  res_q;
  logic [65:0]  blk;
  logic [6:0]   fill;
  logic [129:0] cat;
  logic         accept;

  assign blk    = {que_gb_data, ctl_gb_header};
  assign fill   = {seq_q, 1'b0};
  assign accept = (seq_q < SEQ_DRAIN);
  // New block lands just above the valid residue bits; the low word goes out.
  assign cat    = ({64'b0, blk} << fill) | {66'b0, res_q};

  always_comb begin
    seq_nxt = 6'd0;
    if (!ctl_gb_reset && accept) seq_nxt = seq_q + 6'd1;
  end

  always_ff @(posedge dlx_clk or negedge dlx_reset_n) begin
    if (!dlx_reset_n) begin
      seq_q        <= 6'd0;
      res_q        <= 64'd0;
      gb_phy_data  <= 64'd0;
      gb_que_stall <= 1'b0;
    end else if (ctl_gb_reset) begin
      seq_q        <= 6'd0;
      res_q        <= 64'd0;
      gb_phy_data  <= 64'd0;
      gb_que_stall <= 1'b0;
    end else if (accept) begin
      seq_q        <= seq_nxt;
      res_q        <= 64'(cat >> 64);
      gb_phy_data  <= cat[63:0];
      gb_que_stall <= (seq_nxt == SEQ_DRAIN);
    end else begin
      // Drain slot (and any unreachable count): flush the full residue word.
      seq_q        <= 6'd0;
      res_q        <= 64'd0;
      gb_phy_data  <= res_q;
      gb_que_stall <= 1'b0;
    end
  end

`ifdef OCX_DLX_TX_GB_HDR_CHK_EN
  logic hdr_bad;
  assign hdr_bad = accept && (ctl_gb_header != HDR_DATA) && (ctl_gb_header != HDR_CTRL);

  always_ff @(posedge dlx_clk or negedge dlx_reset_n) begin
    if (!dlx_reset_n)      gb_ctl_hdr_err <= 1'b0;
    else if (ctl_gb_reset) gb_ctl_hdr_err <= 1'b0;
    else if (hdr_bad)      gb_ctl_hdr_err <= 1'b1;
  end
`else
  assign gb_ctl_hdr_err = 1'b0;
`endif

endmodule
